// File: rtl/game_pkg.sv
// Shared definitions for the round sequencer slice.
//   state_t      : FSM state encoding, also exported on the state_o debug port
//   DIGIT_W      : width of one pattern digit
//   PATTERN_W    : width of the full pattern
//   MAX_LEVEL_C  : number of digits in the pattern, which is also the highest level
package game_pkg;

  localparam int DIGIT_W     = 4;
  localparam int PATTERN_W   = 28;
  localparam int MAX_LEVEL_C = PATTERN_W / DIGIT_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHOW  = 3'd2,
    S_ENTRY = 3'd3,
    S_CHECK = 3'd4,
    S_WIN   = 3'd5,
    S_LOSE  = 3'd6,
    S_DONE  = 3'd7
  } state_t;

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter with an expire flag.
//   clock    : rising-edge clock
//   rst      : asynchronous active-low reset
//   load     : load load_val this cycle (wins over counting)
//   load_val : value to load; the flag rises load_val+1 cycles after the load cycle
//   expired  : high while the count is zero
// A load of N-1 therefore gives exactly N cycles before the owner sees expired.
module dwell_timer #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/round_sequencer.sv
// Round sequencer for a pattern-memory game: requests a pattern, displays it
// digit by digit, collects the player's answer digits, then acts on the verdict.
//   clock, rst      : rising-edge clock, asynchronous active-low reset
//   auth_bit        : player authenticated (level); dropping it aborts the round
//   logout          : logout request (level); aborts the round
//   start_btn       : one-cycle pulse, starts a round from IDLE/LOSE/DONE
//   punch_button    : one-cycle pulse, commits one answer digit in ENTRY
//   time_stop       : external timer expired; loses the round in SHOW/ENTRY
//   cmp_win/loose   : verdict from the comparison datapath, sampled in CHECK
//   rng_button      : one-cycle pulse requesting a new pattern (LOAD)
//   reg_enable2     : answer shift register enable (ENTRY)
//   level_num       : current level, 1..MAX_LEVEL
//   levelupdated    : one-cycle pulse, coincident with the new level_num value
//   show_valid/idx  : pattern digit display strobe and digit index
//   game_over       : held in LOSE and DONE
//   state_o         : FSM state for debug
// Optional feature: define ROUND_TIMEOUT_EN to lose the round after
// TIMEOUT_CYCLES cycles in ENTRY without a punch. The dwell timer is shared
// between the SHOW digit dwell and this timeout.
module round_sequencer
  import game_pkg::*;
#(
  parameter int SHOW_CYCLES    = 50_000_000,
  parameter int MAX_LEVEL      = MAX_LEVEL_C,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       auth_bit,
  input  logic       logout,
  input  logic       start_btn,
  input  logic       punch_button,
  input  logic       time_stop,
  input  logic       cmp_win,
  input  logic       cmp_loose,
  output logic       rng_button,
  output logic       reg_enable2,
  output logic [3:0] level_num,
  output logic       levelupdated,
  output logic       show_valid,
  output logic [2:0] show_idx,
  output logic       game_over,
  output logic [2:0] state_o
);

  // Timer sized for the longer of the two dwell uses.
  localparam int DWELL_MAX = (SHOW_CYCLES > TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES;
  localparam int TW        = $clog2(DWELL_MAX + 1);

  state_t     state_q, next_state;
  logic [3:0] level_q, next_level;
  logic [2:0] idx_q, next_idx;
  logic [2:0] punch_cnt_q;
  logic       levelupdated_q, lvl_up;
  logic       tmr_load, tmr_expired;
  logic [TW-1:0] tmr_val;
  logic       punch_done, last_digit, abort;

  dwell_timer #(.W(TW)) u_dwell (
    .clock    (clock),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  // The punch being accepted this cycle completes the answer.
  assign punch_done = (({1'b0, punch_cnt_q} + 4'd1) == level_q);
  assign last_digit = ({1'b0, idx_q} == (level_q - 4'd1));
  assign abort      = (state_q != S_IDLE) && (logout || !auth_bit);

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    next_state = state_q;
    next_level = level_q;
    next_idx   = idx_q;
    tmr_load   = 1'b0;
    tmr_val    = TW'(SHOW_CYCLES - 1);
    lvl_up     = 1'b0;

    case (state_q)
      S_IDLE: if (start_btn && auth_bit) next_state = S_LOAD;

      S_LOAD: begin
        next_state = S_SHOW;
        next_idx   = '0;
        tmr_load   = 1'b1;
      end

      S_SHOW: begin
        if (tmr_expired) begin
          if (last_digit) begin
            next_state = S_ENTRY;
`ifdef ROUND_TIMEOUT_EN
            tmr_load = 1'b1;
            tmr_val  = TW'(TIMEOUT_CYCLES - 1);
`endif
          end else begin
            next_idx = idx_q + 3'd1;
            tmr_load = 1'b1;
          end
        end
      end

      S_ENTRY: begin
        if (punch_button && punch_done) next_state = S_CHECK;
`ifdef ROUND_TIMEOUT_EN
        // Each accepted punch restarts the inactivity window.
        if (punch_button) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(TIMEOUT_CYCLES - 1);
        end else if (tmr_expired) begin
          next_state = S_LOSE;
        end
`endif
      end

      // A simultaneous win and loose verdict counts as a loss.
      S_CHECK: begin
        if (cmp_loose)    next_state = S_LOSE;
        else if (cmp_win) next_state = S_WIN;
      end

      S_WIN: begin
        if (level_q < 4'(MAX_LEVEL)) begin
          next_level = level_q + 4'd1;
          lvl_up     = 1'b1;
          next_state = S_LOAD;
        end else begin
          next_state = S_DONE;
        end
      end

      S_LOSE, S_DONE: begin
        if (start_btn && auth_bit) begin
          next_level = 4'd1;
          next_state = S_LOAD;
        end
      end
    endcase

    if ((state_q == S_SHOW || state_q == S_ENTRY) && time_stop) next_state = S_LOSE;

    // Logout / de-authentication overrides everything else.
    if (abort) begin
      next_state = S_IDLE;
      next_level = 4'd1;
      lvl_up     = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      level_q        <= 4'd1;
      idx_q          <= '0;
      punch_cnt_q    <= '0;
      levelupdated_q <= 1'b0;
    end else begin
      state_q        <= next_state;
      level_q        <= next_level;
      idx_q          <= next_idx;
      levelupdated_q <= lvl_up;
      // Held at zero outside ENTRY, so it is clear on every entry and stray
      // punches elsewhere never count.
      if (state_q != S_ENTRY)  punch_cnt_q <= '0;
      else if (punch_button)   punch_cnt_q <= punch_cnt_q + 3'd1;
    end
  end

  assign rng_button   = (state_q == S_LOAD);
  assign reg_enable2  = (state_q == S_ENTRY);
  assign show_valid   = (state_q == S_SHOW);
  assign show_idx     = show_valid ? idx_q : 3'd0;
  assign game_over    = (state_q == S_LOSE) || (state_q == S_DONE);
  assign level_num    = level_q;
  assign levelupdated = levelupdated_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Scoreboard bench for round_sequencer. The stimulus pushes the expected trace
// of output tuples (with the number of cycles each is held, 0 = don't care);
// a monitor on the falling edge pops and compares one entry each time the
// observed tuple changes.
module tb_round_sequencer;
  import game_pkg::*;

  localparam int SHOW = 4;
  localparam int TMO  = 10;

  logic clock = 1'b0;
  logic rst = 1'b1;
  logic auth_bit = 1'b0, logout = 1'b0, start_btn = 1'b0, punch_button = 1'b0;
  logic time_stop = 1'b0, cmp_win = 1'b0, cmp_loose = 1'b0;
  logic rng_button, reg_enable2, levelupdated, show_valid, game_over;
  logic [3:0] level_num;
  logic [2:0] show_idx, state_o;

  always #5 clock = ~clock;

  round_sequencer #(.SHOW_CYCLES(SHOW), .MAX_LEVEL(7), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .rst(rst), .auth_bit(auth_bit), .logout(logout),
    .start_btn(start_btn), .punch_button(punch_button), .time_stop(time_stop),
    .cmp_win(cmp_win), .cmp_loose(cmp_loose), .rng_button(rng_button),
    .reg_enable2(reg_enable2), .level_num(level_num), .levelupdated(levelupdated),
    .show_valid(show_valid), .show_idx(show_idx), .game_over(game_over),
    .state_o(state_o)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] lvl;
    logic       sv;
    logic [2:0] idx;
    logic       go;
    logic       rng;
    logic       en;
    logic       lu;
  } obs_t;

  typedef struct {
    obs_t  o;
    int    hold;
    string name;
  } exp_t;

  typedef enum {M_WIN, M_LOSE, M_BOTH, M_AUTHDROP, M_TSTOP, M_TIMEOUT, M_RESET, M_LOGOUT} mode_e;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic obs_t mk(state_t s, int lvl, bit sv, int idx, bit lu);
    obs_t o;
    o.st  = s;
    o.lvl = 4'(lvl);
    o.sv  = sv;
    o.idx = 3'(idx);
    o.go  = (s == S_LOSE) || (s == S_DONE);
    o.rng = (s == S_LOAD);
    o.en  = (s == S_ENTRY);
    o.lu  = lu;
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("st=%0d lvl=%0d sv=%0b idx=%0d go=%0b rng=%0b en=%0b lu=%0b",
                     o.st, o.lvl, o.sv, o.idx, o.go, o.rng, o.en, o.lu);
  endfunction

  task automatic push(input obs_t o, input int hold, input string name);
    exp_t e;
    e.o = o; e.hold = hold; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic score(input obs_t o, input int hold);
    exp_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event: got %s hold=%0d, required no further event", fmt(o), hold);
    end else begin
      e = exp_q.pop_front();
      if (o !== e.o || (e.hold != 0 && hold != e.hold)) begin
        miscompares++;
        $display("FAIL %s: got %s hold=%0d, required %s hold=%0d",
                 e.name, fmt(o), hold, fmt(e.o), e.hold);
      end
    end
  endtask

  task automatic check_now(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: report each tuple with the number of cycles it was held once it changes.
  obs_t prev, cur;
  int   hold = 0;
  bit   have_prev = 1'b0;

  always @(negedge clock) begin
    cur = '{st: state_o, lvl: level_num, sv: show_valid, idx: show_idx, go: game_over,
            rng: rng_button, en: reg_enable2, lu: levelupdated};
    if (!have_prev) begin
      prev = cur; hold = 1; have_prev = 1'b1;
    end else if (cur == prev) begin
      hold++;
    end else begin
      score(prev, hold);
      prev = cur; hold = 1;
    end
  end

  // One round at level lvl. Entered on a falling edge; g is the punch spacing,
  // w the extra cycles spent in CHECK (with time_stop high, which must be ignored).
  task automatic play_level(input int lvl, input mode_e mode, input bit need_start,
                            input bit lu_in, input int g, input int w);
    bit found = 1'b0;
    string p = $sformatf("L%0d_%s", lvl, mode.name());
    push(mk(S_LOAD, lvl, 0, 0, lu_in), 1, {p, "_load"});
    if (mode == M_LOGOUT) begin
      push(mk(S_SHOW, lvl, 1, 0, 0), SHOW, {p, "_show0"});
      push(mk(S_SHOW, lvl, 1, 1, 0), 1, {p, "_show1"});
      push(mk(S_IDLE, 1, 0, 0, 0), 0, {p, "_idle"});
    end else begin
      for (int k = 0; k < lvl; k++) push(mk(S_SHOW, lvl, 1, k, 0), SHOW, $sformatf("%s_show%0d", p, k));
      case (mode)
        M_TSTOP:   begin push(mk(S_ENTRY, lvl, 0, 0, 0), 1, {p, "_entry"});   push(mk(S_LOSE, lvl, 0, 0, 0), 0, {p, "_lose"}); end
        M_TIMEOUT: begin push(mk(S_ENTRY, lvl, 0, 0, 0), TMO, {p, "_entry"}); push(mk(S_LOSE, lvl, 0, 0, 0), 0, {p, "_lose"}); end
        M_RESET:   begin push(mk(S_ENTRY, lvl, 0, 0, 0), 1, {p, "_entry"});   push(mk(S_IDLE, 1, 0, 0, 0), 0, {p, "_idle"}); end
        default: begin
          push(mk(S_ENTRY, lvl, 0, 0, 0), 1 + (lvl - 1) * g, {p, "_entry"});
          push(mk(S_CHECK, lvl, 0, 0, 0), w + 1, {p, "_check"});
          case (mode)
            M_WIN: begin
              push(mk(S_WIN, lvl, 0, 0, 0), 1, {p, "_win"});
              if (lvl == 7) push(mk(S_DONE, 7, 0, 0, 0), 0, {p, "_done"});
            end
            M_AUTHDROP: push(mk(S_IDLE, 1, 0, 0, 0), 0, {p, "_idle"});
            default:    push(mk(S_LOSE, lvl, 0, 0, 0), 0, {p, "_lose"});
          endcase
        end
      endcase
    end

    if (need_start) begin
      start_btn = 1'b1; @(negedge clock); start_btn = 1'b0;
    end
    for (int i = 1; i <= 300; i++) begin
      @(negedge clock);
      if (i == 3) punch_button = 1'b1;   // stray punch while the pattern is shown
      if (i == 4) punch_button = 1'b0;
      if (mode == M_LOGOUT ? (show_valid && show_idx == 3'd1) : reg_enable2) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      vectors++; miscompares++;
      $display("FAIL %s_wait: got no target state within 300 cycles, required it", p);
      return;
    end

    case (mode)
      M_LOGOUT: begin logout = 1'b1; @(negedge clock); logout = 1'b0; end
      M_TSTOP:  begin time_stop = 1'b1; @(negedge clock); time_stop = 1'b0; end
      M_TIMEOUT: begin
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
          @(negedge clock);
          found = game_over;
        end
        if (!found) begin
          vectors++; miscompares++;
          $display("FAIL %s_timeout: got game_over=0 after 50 cycles, required 1", p);
        end
      end
      M_RESET: begin
        #2 rst = 1'b0;
        #1 check_now({p, "_async_reset"}, {8'(state_o), 4'(level_num), 3'd0, reg_enable2},
                     {8'(S_IDLE), 4'd1, 3'd0, 1'b0});
        @(negedge clock); @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        check_now({p, "_first_cycle_after_release"}, {11'd0, state_o, rng_button, levelupdated},
                  {11'd0, 3'(S_IDLE), 2'b00});
      end
      default: begin
        for (int k = 0; k < lvl; k++) begin
          punch_button = 1'b1; @(negedge clock); punch_button = 1'b0;
          if (k < lvl - 1) repeat (g - 1) @(negedge clock);
        end
        if (w > 0) begin
          time_stop = 1'b1;
          repeat (w) @(negedge clock);
          time_stop = 1'b0;
        end
        case (mode)
          M_WIN:      cmp_win = 1'b1;
          M_LOSE:     cmp_loose = 1'b1;
          M_BOTH:     begin cmp_win = 1'b1; cmp_loose = 1'b1; end
          default:    auth_bit = 1'b0;
        endcase
        @(negedge clock);
        cmp_win = 1'b0; cmp_loose = 1'b0; auth_bit = 1'b1;
      end
    endcase
  endtask

  initial begin
    #2 rst = 1'b0;
    push(mk(S_IDLE, 1, 0, 0, 0), 0, "reset_idle");
    repeat (3) @(negedge clock);
    rst = 1'b1;
    // Start without authentication must be ignored.
    start_btn = 1'b1; @(negedge clock); start_btn = 1'b0;
    repeat (2) @(negedge clock);
    auth_bit = 1'b1;
    @(negedge clock);

    // Full climb to MAX_LEVEL, then DONE.
    for (int l = 1; l <= 7; l++) play_level(l, M_WIN, l == 1, l > 1, (l % 2) + 1, l % 3);
    repeat (2) @(negedge clock);
    // Restart from DONE, then both verdicts at level 2.
    play_level(1, M_WIN, 1'b1, 1'b0, 1, 0);
    play_level(2, M_BOTH, 1'b0, 1'b1, 1, 1);
    repeat (2) @(negedge clock);
    // Climb to level 4 and log out mid-SHOW.
    play_level(1, M_WIN, 1'b1, 1'b0, 1, 0);
    play_level(2, M_WIN, 1'b0, 1'b1, 2, 0);
    play_level(3, M_WIN, 1'b0, 1'b1, 1, 0);
    play_level(4, M_LOGOUT, 1'b0, 1'b1, 1, 0);
    repeat (2) @(negedge clock);
    // time_stop in ENTRY.
    play_level(1, M_TSTOP, 1'b1, 1'b0, 1, 0);
    // De-authentication in CHECK at level 2.
    play_level(1, M_WIN, 1'b1, 1'b0, 1, 0);
    play_level(2, M_AUTHDROP, 1'b0, 1'b1, 1, 2);
    repeat (2) @(negedge clock);
    // Plain loose verdict.
    play_level(1, M_LOSE, 1'b1, 1'b0, 1, 1);
`ifdef ROUND_TIMEOUT_EN
    play_level(1, M_TIMEOUT, 1'b1, 1'b0, 1, 0);
`endif
    // Asynchronous reset mid-ENTRY at level 2.
    play_level(1, M_WIN, 1'b1, 1'b0, 1, 0);
    play_level(2, M_RESET, 1'b0, 1'b1, 1, 0);
    repeat (3) @(negedge clock);

    // Flush the final held tuple, then anything left unmatched.
    @(posedge clock);
    #2;
    score(prev, 0);
    while (exp_q.size() > 0) begin
      vectors++; miscompares++;
      $display("FAIL %s: got no event, required %s", exp_q[0].name, fmt(exp_q[0].o));
      void'(exp_q.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
